// File: rtl/oc_uart_host.sv
// Host-side 8N1/8N2 UART transceiver facing the chip's control UART.
// Byte streams use valid/ready; TX and RX run independently off one clock.
module oc_uart_host #(
    parameter int ClockHz    = 100_000_000,
    parameter int Baud       = 10_000_000,
    parameter int StopBits   = 1,
    parameter int CountWidth = 16
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [7:0]            txData,
    input  logic                  txValid,
    output logic                  txReady,
    output logic                  uartTx,
    input  logic                  uartRx,
    output logic [7:0]            rxData,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic                  errorFraming,
    output logic                  errorOverrun,
    output logic [CountWidth-1:0] txCount,
    output logic [CountWidth-1:0] rxCount
);
    localparam int Cpb     = ClockHz / Baud;
    localparam int StopCyc = StopBits * Cpb;
    localparam int CntW    = $clog2(2 * Cpb + 1);

    localparam logic [CntW-1:0] CpbM1  = CntW'(Cpb - 1);
    localparam logic [CntW-1:0] StopM1 = CntW'(StopCyc - 1);
    localparam logic [CntW-1:0] HalfB  = CntW'(Cpb / 2);

    if (Cpb < 4) begin : g_cpb_check
        $error("oc_uart_host: ClockHz/Baud must be at least 4");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_stop_check
        $error("oc_uart_host: StopBits must be 1 or 2");
    end

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t             tx_state, tx_state_n;
    logic [CntW-1:0]       tx_cnt, tx_cnt_n;
    logic [2:0]            tx_bit, tx_bit_n;
    logic [7:0]            tx_sh, tx_sh_n;
    logic                  tx_line_n;
    logic [CountWidth-1:0] tx_count_n;

    assign txReady = (tx_state == TX_IDLE);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uartTx   <= 1'b1;
            txCount  <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            uartTx   <= tx_line_n;
            txCount  <= tx_count_n;
        end
    end

    // The shift register always presents the next data bit in tx_sh[0].
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_line_n  = uartTx;
        tx_count_n = txCount;
        if (tx_state != TX_IDLE) tx_cnt_n = tx_cnt - 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_line_n = 1'b1;
                if (txValid) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = CpbM1;
                    tx_sh_n    = txData;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = CpbM1;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_sh[0];
                    tx_sh_n    = tx_sh >> 1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = CpbM1;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_cnt_n   = StopM1;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n  = tx_bit + 3'd1;
                        tx_line_n = tx_sh[0];
                        tx_sh_n   = tx_sh >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_IDLE;
                    tx_count_n = txCount + 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHIGH} rx_state_t;

    rx_state_t             rx_state, rx_state_n;
    logic [1:0]            rx_sync;
    logic                  rx_s, rx_prev;
    logic [CntW-1:0]       rx_cnt, rx_cnt_n;
    logic [2:0]            rx_bit, rx_bit_n;
    logic [7:0]            rx_sh, rx_sh_n;
    logic [7:0]            rx_data_n;
    logic                  rx_valid_n, fe_n, oe_n;
    logic [CountWidth-1:0] rx_count_n;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rx_sync      <= 2'b11;
            rx_prev      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_sh        <= '0;
            rxData       <= '0;
            rxValid      <= 1'b0;
            rxCount      <= '0;
            errorFraming <= 1'b0;
            errorOverrun <= 1'b0;
        end else begin
            rx_sync      <= {rx_sync[0], uartRx};
            rx_prev      <= rx_s;
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_bit       <= rx_bit_n;
            rx_sh        <= rx_sh_n;
            rxData       <= rx_data_n;
            rxValid      <= rx_valid_n;
            rxCount      <= rx_count_n;
            errorFraming <= fe_n;
            errorOverrun <= oe_n;
        end
    end

    // Start bit is re-checked half a bit after the falling edge; later samples are bit-spaced.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_data_n  = rxData;
        rx_valid_n = rxValid && !rxReady;
        rx_count_n = rxCount;
        fe_n       = 1'b0;
        oe_n       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = HalfB;
                end
            end
            RX_START: begin
                rx_cnt_n = rx_cnt - 1'b1;
                if (rx_cnt == '0) begin
                    if (rx_s) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = CpbM1;
                        rx_bit_n   = '0;
                    end
                end
            end
            RX_DATA: begin
                rx_cnt_n = rx_cnt - 1'b1;
                if (rx_cnt == '0) begin
                    rx_sh_n  = {rx_s, rx_sh[7:1]};
                    rx_cnt_n = CpbM1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                rx_cnt_n = rx_cnt - 1'b1;
                if (rx_cnt == '0) begin
                    if (rx_s) begin
                        rx_state_n = RX_IDLE;
                        if (!rxValid || rxReady) begin
                            rx_data_n  = rx_sh;
                            rx_valid_n = 1'b1;
                            rx_count_n = rxCount + 1'b1;
                        end else begin
                            oe_n = 1'b1;
                        end
                    end else begin
                        fe_n       = 1'b1;
                        rx_state_n = RX_WAITHIGH;
                    end
                end
            end
            RX_WAITHIGH: begin
                if (rx_s) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_oc_uart_host.sv
// Bench for oc_uart_host: frame-offset TX model and byte-queue RX model
// checked every cycle, plus directed literal expectations.
module tb_oc_uart_host;
    localparam int CPB   = 10;
    localparam int SB    = 1;
    localparam int FRAME = (9 + SB) * CPB;

    logic        clock = 1'b0;
    logic        resetN = 1'b1;
    logic [7:0]  txData = 8'h00;
    logic        txValid = 1'b0;
    logic        txReady;
    logic        uartTx;
    logic        uartRx;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady = 1'b1;
    logic        errorFraming, errorOverrun;
    logic [15:0] txCount, rxCount;

    logic loop = 1'b0;
    logic rx_drv = 1'b1;
    assign uartRx = loop ? uartTx : rx_drv;

    oc_uart_host #(.ClockHz(100_000_000), .Baud(10_000_000), .StopBits(SB), .CountWidth(16)) dut (
        .clock(clock), .resetN(resetN),
        .txData(txData), .txValid(txValid), .txReady(txReady), .uartTx(uartTx),
        .uartRx(uartRx), .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
        .errorFraming(errorFraming), .errorOverrun(errorOverrun),
        .txCount(txCount), .rxCount(rxCount)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    // Line level k cycles into a frame carrying byte b.
    function automatic int tx_level(input logic [7:0] b, input int k);
        int i;
        i = k / CPB;
        if (i == 0) return 0;
        if (i <= 8) return int'(b[i-1]);
        return 1;
    endfunction

    // ---------------- model + compare ----------------
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_k = 0;
    logic [7:0]  m_byte = 8'h00;
    logic [15:0] m_txcnt = 16'h0;
    logic [7:0]  q[$];
    logic [15:0] pops = 16'h0;
    int          fe_cnt = 0;
    int          oe_cnt = 0;
    bit          spacing_on = 0;
    int          last_rx = -1;

    always @(negedge clock) begin
        cyc++;
        if (!resetN) begin
            m_busy  = 0;
            m_k     = 0;
            m_txcnt = 16'h0;
            pops    = 16'h0;
            q.delete();
            last_rx = -1;
            chk("rst_rxData", int'(rxData), 0);
            chk("rst_rxValid", int'(rxValid), 0);
            chk("rst_errorFraming", int'(errorFraming), 0);
            chk("rst_errorOverrun", int'(errorOverrun), 0);
        end
        chk("txReady", int'(txReady), m_busy ? 0 : 1);
        chk("uartTx", int'(uartTx), m_busy ? tx_level(m_byte, m_k) : 1);
        chk("txCount", int'(txCount), int'(m_txcnt));
        chk("rxCount", int'(rxCount), int'(pops + 16'(rxValid)));
        if (errorFraming) fe_cnt++;
        if (errorOverrun) oe_cnt++;
        if (rxValid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got %0h, expected no byte", rxData);
            end else begin
                chk("rxData", int'(rxData), int'(q[0]));
                if (rxReady) begin
                    void'(q.pop_front());
                    pops++;
                    if (spacing_on) begin
                        if (last_rx >= 0) chk("rx_spacing", cyc - last_rx, FRAME + 1);
                        last_rx = cyc;
                    end
                end
            end
        end
        if (resetN) begin
            if (!m_busy) begin
                if (txValid) begin
                    m_busy = 1;
                    m_k    = 0;
                    m_byte = txData;
                end
            end else if (m_k == FRAME - 1) begin
                m_busy = 0;
                m_txcnt++;
            end else begin
                m_k++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        cyc_wait(3);
        resetN = 1'b1;
        cyc_wait(2);
    endtask

    task automatic send_tx(input logic [7:0] b);
        int n;
        n = 0;
        txData  = b;
        txValid = 1'b1;
        @(negedge clock);
        while (!txReady && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL tx_accept_timeout: got no txReady, expected within 500 cycles");
        end
        @(posedge clock);
        #1;
        txValid = 1'b0;
        txData  = 8'h00;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            cyc_wait(CPB);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] lvl_exp;
        logic       lv [0:109];
        logic       rdy[0:109];
        int         lows, fe0, oe0;

        #1 resetN = 1'b0;
        @(negedge clock);
        chk("rst_uartTx", int'(uartTx), 1);
        chk("rst_txReady", int'(txReady), 1);
        chk("rst_txCount", int'(txCount), 0);
        chk("rst_rxCount", int'(rxCount), 0);
        cyc_wait(2);
        resetN = 1'b1;
        cyc_wait(2);

        // 0xA5: start, 1,0,1,0,0,1,0,1, stop
        lvl_exp = 10'b1101001010;
        send_tx(8'hA5);
        for (int i = 0; i < 110; i++) begin
            @(negedge clock);
            lv[i]  = uartTx;
            rdy[i] = txReady;
        end
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("a5_bit%0d_first", b), int'(lv[b*10]), int'(lvl_exp[b]));
            chk($sformatf("a5_bit%0d_last", b), int'(lv[b*10+9]), int'(lvl_exp[b]));
        end
        chk("a5_idle_after", int'(lv[100]), 1);
        lows = 0;
        for (int i = 0; i < 110; i++) if (!rdy[i]) lows++;
        chk("a5_txReady_low_cycles", lows, 100);
        chk("a5_txReady_back", int'(rdy[100]), 1);
        chk("a5_txCount", int'(txCount), 1);
        cyc_wait(1);

        // loopback, back-to-back
        do_reset();
        loop = 1'b1;
        rxReady = 1'b1;
        spacing_on = 1;
        fe0 = fe_cnt;
        oe0 = oe_cnt;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h3C);
        send_tx(8'h00);
        send_tx(8'hFF);
        send_tx(8'h3C);
        cyc_wait(130);
        chk("loop_rxCount", int'(rxCount), 3);
        chk("loop_txCount", int'(txCount), 3);
        chk("loop_pending", q.size(), 0);
        chk("loop_framing", fe_cnt - fe0, 0);
        chk("loop_overrun", oe_cnt - oe0, 0);
        spacing_on = 0;
        loop = 1'b0;

        // bad stop bit followed by a break, then a good frame
        do_reset();
        fe0 = fe_cnt;
        send_rx(8'h55, 1'b0);
        cyc_wait(50);
        rx_drv = 1'b1;
        cyc_wait(20);
        chk("break_framing", fe_cnt - fe0, 1);
        chk("break_rxCount", int'(rxCount), 0);
        q.push_back(8'h12);
        send_rx(8'h12, 1'b1);
        cyc_wait(20);
        chk("after_break_rxCount", int'(rxCount), 1);
        chk("after_break_pending", q.size(), 0);
        chk("after_break_framing", fe_cnt - fe0, 1);

        // overrun: consumer stalled
        do_reset();
        rxReady = 1'b0;
        oe0 = oe_cnt;
        q.push_back(8'h11);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        cyc_wait(20);
        @(negedge clock);
        chk("ovr_rxValid", int'(rxValid), 1);
        chk("ovr_rxData", int'(rxData), 8'h11);
        chk("ovr_pulses", oe_cnt - oe0, 1);
        chk("ovr_rxCount", int'(rxCount), 1);
        cyc_wait(1);
        rxReady = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("ovr_rxValid_drop", int'(rxValid), 0);
        chk("ovr_rxCount_after", int'(rxCount), 1);
        cyc_wait(1);

        // short glitch is a false start
        do_reset();
        fe0 = fe_cnt;
        oe0 = oe_cnt;
        rx_drv = 1'b0;
        cyc_wait(3);
        rx_drv = 1'b1;
        cyc_wait(30);
        chk("glitch_rxCount", int'(rxCount), 0);
        chk("glitch_framing", fe_cnt - fe0, 0);
        chk("glitch_overrun", oe_cnt - oe0, 0);
        q.push_back(8'h81);
        send_rx(8'h81, 1'b1);
        cyc_wait(20);
        chk("glitch_next_rxCount", int'(rxCount), 1);
        chk("glitch_next_pending", q.size(), 0);

        // reset in the middle of a TX frame
        do_reset();
        send_tx(8'hC3);
        cyc_wait(40);
        resetN = 1'b0;
        @(negedge clock);
        chk("midrst_uartTx", int'(uartTx), 1);
        chk("midrst_txReady", int'(txReady), 1);
        cyc_wait(3);
        resetN = 1'b1;
        cyc_wait(2);
        send_tx(8'h5A);
        cyc_wait(FRAME + 10);
        chk("midrst_txCount", int'(txCount), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/oc_uart_host.md
Name: oc_uart_host

Overview:
- Host-side end of the board control UART: the transceiver that talks to the chip's control UART.
- Its uartTx drives the chip's UART receive pin (USB_UART_TX). Its uartRx samples the chip's UART transmit pin (USB_UART_RX).
- Byte-level valid/ready streams face the host logic: a synthesizable command injector in the harness, or an on-board host controller.
- Line format is fixed 8N1 (or 8N2), LSB first, idle high.

Parameters:
- ClockHz, 100_000_000, frequency of clock in Hz.
- Baud, 10_000_000, line rate. CyclesPerBit = ClockHz/Baud, truncated. Elaboration error if CyclesPerBit < 4.
- StopBits, 1, transmitted stop bits (1 or 2). RX always checks exactly one stop bit.
- CountWidth, 16, width of the byte counters.

Ports:
- clock  in  1  sole clock.
- resetN  in  1  asynchronous active-low reset.
- txData  in  8  byte to send.
- txValid  in  1  txData valid.
- txReady  out  1  transmitter accepts txData this cycle.
- uartTx  out  1  serial line to chip RX; idle high.
- uartRx  in  1  serial line from chip TX; asynchronous to clock.
- rxData  out  8  received byte.
- rxValid  out  1  rxData valid; held until accepted.
- rxReady  in  1  consumer accepts rxData.
- errorFraming  out  1  one-cycle pulse on a bad stop bit.
- errorOverrun  out  1  one-cycle pulse when a byte is dropped.
- txCount  out  CountWidth  bytes transmitted, wraps.
- rxCount  out  CountWidth  bytes delivered to rxValid, wraps.

Behaviour:
- Reset (resetN low, asynchronous assert, synchronous-release usage): uartTx=1, txReady=1, rxValid=0, rxData=0, errorFraming=0, errorOverrun=0, txCount=0, rxCount=0. Both FSMs go to IDLE. The RX synchronizer flops reset to 1.
- Reset mid-frame: the TX frame is abandoned and uartTx returns high immediately. A partial RX byte is discarded.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: txReady=1. On txValid&&txReady, latch txData and go to START; txReady drops the next cycle.
  - START drives 0, DATA drives bit0..bit7, STOP drives 1. Each bit lasts exactly CyclesPerBit cycles.
  - STOP lasts StopBits*CyclesPerBit cycles.
  - The first START cycle is the cycle after acceptance. uartTx is registered.
  - txCount increments when STOP completes. The FSM returns to IDLE with txReady=1 in the following cycle.
  - Back-to-back: a byte accepted in that IDLE cycle starts its START bit the next cycle.
  - Frame period for back-to-back bytes is (9+StopBits)*CyclesPerBit+1 cycles.
  - txValid without txReady is ignored. txData only needs to be stable in the accept cycle.
- RX synchronizer: uartRx passes through a 2-flop synchronizer (2 cycles latency). All RX timing below refers to the synchronized signal.
- RX FSM states: IDLE, START, DATA, STOP, WAITHIGH.
  - IDLE: a 1->0 transition moves to START with the bit counter loaded to CyclesPerBit/2.
  - START: at expiry, sample. If the line is 1, this is a false start; return to IDLE with no error. If 0, go to DATA.
  - DATA: sample 8 bits, each CyclesPerBit after the previous sample, LSB first.
  - STOP: sample one more bit at +CyclesPerBit.
- RX stop-bit outcomes:
  - Stop=1, and rxValid=0 or rxReady=1 in that cycle: rxData/rxValid update the next cycle, rxCount increments, FSM returns to IDLE.
  - Stop=1, but rxValid=1 and rxReady=0: the new byte is dropped, the old byte is kept, errorOverrun pulses, rxCount is unchanged.
  - Stop=0: errorFraming pulses, the byte is discarded, and the FSM enters WAITHIGH. It stays there until the line is 1, then goes to IDLE. A break (line held low) yields exactly one framing error.
- rxValid clears the cycle after rxValid&&rxReady unless a new byte is delivered in that same cycle. A byte completing in the same cycle a consumer accepts is not an overrun.
- Counters wrap from 2^CountWidth-1 to 0 without flagging.
- TX and RX are fully independent. A simultaneous TX accept and RX delivery is legal.

Test Plan (ClockHz=100M, Baud=10M, so CyclesPerBit=10):
- Send 0xA5 → uartTx levels 0,1,0,1,0,0,1,0,1,1, each exactly 10 cycles. txReady low for 100 cycles. txCount=1.
- Loop uartTx to uartRx and send 0x00, 0xFF, 0x3C back-to-back with rxReady=1 → rxData 0x00, 0xFF, 0x3C in order. rxCount=3. Frame spacing is 101 cycles. No error pulses.
- Drive frame 0x55 with stop bit 0, then hold the line low 50 cycles → one errorFraming pulse, no rxValid. The next good frame 0x12 is received correctly.
- rxReady=0 and send 0x11 then 0x22 → rxData stays 0x11 and errorOverrun pulses once. Raise rxReady → rxValid drops, rxCount=1.
- 3-cycle low glitch on uartRx → no rxValid and no error. The following frame 0x81 is received.
- Assert resetN low at cycle 40 of a TX frame → uartTx=1 and txReady=1 during reset. After release, 0x5A transmits correctly.
